// File: rtl/slink_apb_pkg.sv
// -----------------------------------------------------------------------------
// slink_apb_pkg
//   Definitions shared by the S-Link APB target and its far-end initiator:
//   packet data IDs, word counts, packet field offsets and the common
//   four-state APB transaction FSM encoding.
// -----------------------------------------------------------------------------
package slink_apb_pkg;

   // Packet data IDs
   localparam logic [7:0]  SLINK_APB_READ_DT       = 8'h30;
   localparam logic [7:0]  SLINK_APB_READ_RSP_DT   = 8'h31;
   localparam logic [7:0]  SLINK_APB_WRITE_DT      = 8'h32;
   localparam logic [7:0]  SLINK_APB_WRITE_RSP_DT  = 8'h33;

   // Packet word counts (payload bytes)
   localparam logic [15:0] SLINK_APB_READ_WC       = 16'd4;
   localparam logic [15:0] SLINK_APB_WRITE_WC      = 16'd8;
   localparam logic [15:0] SLINK_APB_READ_RSP_WC   = 16'd5;
   localparam logic [15:0] SLINK_APB_WRITE_RSP_WC  = 16'd1;

   // Header layout, common to requests and responses
   localparam int HDR_DT_LSB      = 0;
   localparam int HDR_WC_LSB      = 8;
   localparam int HDR_W           = 24;

   // Request payload layout
   localparam int REQ_ADDR_LSB    = 24;
   localparam int REQ_WDATA_LSB   = 56;

   // Response payload layout
   localparam int RSP_PAYLOAD_LSB = 24;
   localparam int RSP_PAYLOAD_W   = 33;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RSP    = 2'd3
   } apb_state_e;

endpackage

// File: rtl/slink_apb_ini_ctrl.sv
// -----------------------------------------------------------------------------
// slink_apb_ini_ctrl
//   Far-end APB initiator of the S-Link APB bridge. Pops request packets from
//   the flow-control l2a interface, replays each one as an APB master
//   transaction and pushes the result back as a response packet on a2l.
//   One transaction is in flight at a time.
//
// Ports
//   apb_clk, apb_reset        clock, asynchronous active-high reset
//   enable                    block enable (synchronous to apb_clk)
//   l2a_valid/data/accept     request word in, combinational one-cycle pop
//   a2l_valid/data/ready      registered response word out
//   apb_*                     APB master interface (outputs registered)
//   bad_dt_err                pulse: request with unsupported DT dropped
//   timeout_err               pulse: APB access abandoned after timeout
// -----------------------------------------------------------------------------
module slink_apb_ini_ctrl
   import slink_apb_pkg::*;
#(
   parameter logic [7:0] APB_READ_DT      = SLINK_APB_READ_DT,
   parameter logic [7:0] APB_READ_RSP_DT  = SLINK_APB_READ_RSP_DT,
   parameter logic [7:0] APB_WRITE_DT     = SLINK_APB_WRITE_DT,
   parameter logic [7:0] APB_WRITE_RSP_DT = SLINK_APB_WRITE_RSP_DT,
   parameter int         REQ_DATA_WIDTH   = 88,
   parameter int         RSP_DATA_WIDTH   = 57,
   parameter int         TIMEOUT_CYCLES   = 256
)(
   input  logic                      apb_clk,
   input  logic                      apb_reset,
   input  logic                      enable,
   input  logic                      l2a_valid,
   input  logic [REQ_DATA_WIDTH-1:0] l2a_data,
   output logic                      l2a_accept,
   output logic                      a2l_valid,
   output logic [RSP_DATA_WIDTH-1:0] a2l_data,
   input  logic                      a2l_ready,
   output logic [31:0]               apb_paddr,
   output logic                      apb_pwrite,
   output logic                      apb_psel,
   output logic                      apb_penable,
   output logic [31:0]               apb_pwdata,
   input  logic [31:0]               apb_prdata,
   input  logic                      apb_pready,
   input  logic                      apb_pslverr,
   output logic                      bad_dt_err,
   output logic                      timeout_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   function automatic logic [RSP_DATA_WIDTH-1:0] pack_rsp(input logic        is_write,
                                                          input logic        slverr,
                                                          input logic [31:0] rdata);
      logic [RSP_PAYLOAD_W-1:0] payload;
      logic [15:0]              wc;
      logic [7:0]               dt;
      if (is_write) begin
         payload = {32'd0, slverr};
         wc      = SLINK_APB_WRITE_RSP_WC;
         dt      = APB_WRITE_RSP_DT;
      end else begin
         payload = {slverr, rdata};
         wc      = SLINK_APB_READ_RSP_WC;
         dt      = APB_READ_RSP_DT;
      end
      return RSP_DATA_WIDTH'({payload, wc, dt});
   endfunction

   apb_state_e                state_q, state_d;
   logic [31:0]               paddr_q, paddr_d;
   logic [31:0]               pwdata_q, pwdata_d;
   logic                      pwrite_q, pwrite_d;
   logic                      psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      a2l_valid_q, a2l_valid_d;
   logic [RSP_DATA_WIDTH-1:0] a2l_data_q, a2l_data_d;
   logic                      bad_dt_err_q, bad_dt_err_d;
   logic                      timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;

   logic [7:0]  req_dt;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_known;
   logic        timeout_hit;
   logic        access_done;
   logic        unused_wc;

   assign req_dt    = l2a_data[HDR_DT_LSB +: 8];
   assign req_addr  = l2a_data[REQ_ADDR_LSB +: 32];
   assign req_wdata = l2a_data[REQ_WDATA_LSB +: 32];
   assign req_known = (req_dt == APB_READ_DT) || (req_dt == APB_WRITE_DT);
   // The word count of a request carries no information we act on.
   assign unused_wc = ^l2a_data[HDR_WC_LSB +: 16];

   // cnt_q counts completed wait cycles; the access is abandoned on the
   // cycle that would be the TIMEOUT_CYCLES-th one without pready.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && !apb_pready && (cnt_q == CNT_LAST);
   assign access_done = apb_pready || timeout_hit;

   always_comb begin
      state_d       = state_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pwrite_d      = pwrite_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      a2l_valid_d   = a2l_valid_q;
      a2l_data_d    = a2l_data_q;
      cnt_d         = cnt_q;
      bad_dt_err_d  = 1'b0;
      timeout_err_d = 1'b0;
      l2a_accept    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable && l2a_valid) begin
               l2a_accept = 1'b1;
               if (req_known) begin
                  paddr_d   = req_addr;
                  pwdata_d  = req_wdata;
                  pwrite_d  = (req_dt == APB_WRITE_DT);
                  psel_d    = 1'b1;
                  penable_d = 1'b0;
                  cnt_d     = '0;
                  state_d   = ST_SETUP;
               end else begin
                  bad_dt_err_d = 1'b1;
               end
            end
         end

         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end

         ST_ACCESS: begin
            // Runs to completion regardless of enable: an APB transfer
            // cannot be legally withdrawn once started.
            if (access_done) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               cnt_d         = '0;
               timeout_err_d = timeout_hit;
               a2l_data_d    = pack_rsp(pwrite_q,
                                        apb_pready ? apb_pslverr : 1'b1,
                                        (apb_pready && !pwrite_q) ? apb_prdata : 32'd0);
               if (enable) begin
                  a2l_valid_d = 1'b1;
                  state_d     = ST_RSP;
               end else begin
                  state_d     = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RSP: begin
            if (!enable || a2l_ready) begin
               a2l_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge apb_clk or posedge apb_reset) begin
      if (apb_reset) begin
         state_q       <= ST_IDLE;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pwrite_q      <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         a2l_valid_q   <= 1'b0;
         a2l_data_q    <= '0;
         bad_dt_err_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pwrite_q      <= pwrite_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         a2l_valid_q   <= a2l_valid_d;
         a2l_data_q    <= a2l_data_d;
         bad_dt_err_q  <= bad_dt_err_d;
         timeout_err_q <= timeout_err_d;
         cnt_q         <= cnt_d;
      end
   end

   assign apb_paddr   = paddr_q;
   assign apb_pwdata  = pwdata_q;
   assign apb_pwrite  = pwrite_q;
   assign apb_psel    = psel_q;
   assign apb_penable = penable_q;
   assign a2l_valid   = a2l_valid_q;
   assign a2l_data    = a2l_data_q;
   assign bad_dt_err  = bad_dt_err_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_slink_apb_ini_ctrl.sv
module tb_slink_apb_ini_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic         l2a_valid = 1'b0;
   logic [87:0]  l2a_data = '0;
   logic         l2a_accept;
   logic         a2l_valid;
   logic [56:0]  a2l_data;
   logic         a2l_ready = 1'b1;
   logic [31:0]  apb_paddr;
   logic         apb_pwrite;
   logic         apb_psel;
   logic         apb_penable;
   logic [31:0]  apb_pwdata;
   logic [31:0]  apb_prdata = '0;
   logic         apb_pready = 1'b0;
   logic         apb_pslverr = 1'b0;
   logic         bad_dt_err;
   logic         timeout_err;

   always #5 clk = ~clk;

   slink_apb_ini_ctrl dut (
      .apb_clk     (clk),
      .apb_reset   (rst),
      .enable      (enable),
      .l2a_valid   (l2a_valid),
      .l2a_data    (l2a_data),
      .l2a_accept  (l2a_accept),
      .a2l_valid   (a2l_valid),
      .a2l_data    (a2l_data),
      .a2l_ready   (a2l_ready),
      .apb_paddr   (apb_paddr),
      .apb_pwrite  (apb_pwrite),
      .apb_psel    (apb_psel),
      .apb_penable (apb_penable),
      .apb_pwdata  (apb_pwdata),
      .apb_prdata  (apb_prdata),
      .apb_pready  (apb_pready),
      .apb_pslverr (apb_pslverr),
      .bad_dt_err  (bad_dt_err),
      .timeout_err (timeout_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // APB completer model: answers after slv_waits wait states, or never when hung.
   int          slv_waits = 0;
   logic [31:0] slv_rdata = '0;
   logic        slv_err   = 1'b0;
   logic        slv_hang  = 1'b0;

   initial begin
      int wcnt;
      wcnt = 0;
      forever begin
         @(posedge clk); #1;
         if (apb_psel && apb_penable && !slv_hang) begin
            if (wcnt >= slv_waits) begin
               apb_pready = 1'b1; apb_prdata = slv_rdata; apb_pslverr = slv_err;
            end else begin
               apb_pready = 1'b0; apb_prdata = '0; apb_pslverr = 1'b0;
               wcnt++;
            end
         end else begin
            apb_pready = 1'b0; apb_prdata = '0; apb_pslverr = 1'b0;
            wcnt = 0;
         end
      end
   end

   // Scoreboard of expected response words.
   logic [56:0] exp_q[$];

   task automatic check_rsp(input string name);
      logic [56:0] e;
      chk({name, "_valid"}, 64'(a2l_valid), 64'd1);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: response seen with empty scoreboard, got 0x%0h", name, a2l_data);
      end else begin
         e = exp_q.pop_front();
         if (a2l_valid) chk({name, "_data"}, 64'(a2l_data), 64'(e));
      end
   endtask

   task automatic drive_req(input logic [7:0] dt, input logic [31:0] addr, input logic [31:0] wdata);
      l2a_data  = {wdata, addr, (dt == 8'h32) ? 16'd8 : 16'd4, dt};
      l2a_valid = 1'b1;
   endtask

   typedef struct {
      logic [7:0]  dt;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] prdata;
      int          waits;
      logic        err;
      logic [7:0]  exp_dt;
      logic [15:0] exp_wc;
      logic [32:0] exp_pl;
   } vec_t;

   vec_t vecs[5];

   // Entered and left at 1 time unit after a rising edge.
   task automatic run_vec(input int i);
      vec_t v;
      int   lat;
      v = vecs[i];
      slv_waits = v.waits; slv_rdata = v.prdata; slv_err = v.err; slv_hang = 1'b0;
      exp_q.push_back({v.exp_pl, v.exp_wc, v.exp_dt});
      drive_req(v.dt, v.addr, v.wdata);
      #1;
      chk($sformatf("v%0d_accept", i), 64'(l2a_accept), 64'd1);
      @(posedge clk); #1;
      l2a_valid = 1'b0;
      chk($sformatf("v%0d_psel", i), 64'(apb_psel), 64'd1);
      chk($sformatf("v%0d_penable_setup", i), 64'(apb_penable), 64'd0);
      chk($sformatf("v%0d_paddr", i), 64'(apb_paddr), 64'(v.addr));
      chk($sformatf("v%0d_pwrite", i), 64'(apb_pwrite), 64'(v.dt == 8'h32));
      chk($sformatf("v%0d_pwdata", i), 64'(apb_pwdata), 64'(v.wdata));
      lat = 1;
      while (!a2l_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(3 + v.waits));
      check_rsp($sformatf("v%0d_rsp", i));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_drop", i), 64'(a2l_valid), 64'd0);
   endtask

   initial begin
      int   n;
      logic flag;
      logic flag2;
      logic [56:0] snap;

      //               dt     addr          wdata         prdata        w  err  exp_dt exp_wc  exp_payload
      vecs[0] = '{8'h32, 32'h0000_1000, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 1'b0, 8'h33, 16'd1, 33'h0_0000_0000};
      vecs[1] = '{8'h30, 32'h0000_2004, 32'h0000_0000, 32'h1234_5678, 3, 1'b1, 8'h31, 16'd5, 33'h1_1234_5678};
      vecs[2] = '{8'h30, 32'h0000_3008, 32'h5555_AAAA, 32'hA5A5_0F0F, 0, 1'b0, 8'h31, 16'd5, 33'h0_A5A5_0F0F};
      vecs[3] = '{8'h32, 32'h0000_4000, 32'h0BAD_F00D, 32'h0000_0000, 1, 1'b1, 8'h33, 16'd1, 33'h0_0000_0001};
      vecs[4] = '{8'h32, 32'hFFFF_FFFC, 32'h0000_0001, 32'h7777_7777, 2, 1'b0, 8'h33, 16'd1, 33'h0_0000_0000};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_psel",      64'(apb_psel), 64'd0);
      chk("rst_penable",   64'(apb_penable), 64'd0);
      chk("rst_paddr",     64'(apb_paddr), 64'd0);
      chk("rst_pwdata",    64'(apb_pwdata), 64'd0);
      chk("rst_pwrite",    64'(apb_pwrite), 64'd0);
      chk("rst_a2l_valid", 64'(a2l_valid), 64'd0);
      chk("rst_a2l_data",  64'(a2l_data), 64'd0);
      chk("rst_accept",    64'(l2a_accept), 64'd0);
      chk("rst_errs",      64'({bad_dt_err, timeout_err}), 64'd0);
      rst = 1'b0;

      // Disabled: a pending request is not taken
      drive_req(8'h30, 32'h0000_0100, 32'd0);
      #1;
      chk("dis_accept", 64'(l2a_accept), 64'd0);
      @(posedge clk); #1;
      chk("dis_psel", 64'(apb_psel), 64'd0);
      l2a_valid = 1'b0;
      enable = 1'b1;
      @(posedge clk); #1;

      // Table-driven transactions
      for (int i = 0; i < 5; i++) run_vec(i);

      // Unknown DT is popped and dropped
      drive_req(8'h40, 32'h0000_0200, 32'd0);
      #1;
      chk("bad_accept", 64'(l2a_accept), 64'd1);
      @(posedge clk); #1;
      l2a_valid = 1'b0;
      chk("bad_pulse", 64'(bad_dt_err), 64'd1);
      chk("bad_psel", 64'(apb_psel), 64'd0);
      @(posedge clk); #1;
      chk("bad_pulse_end", 64'(bad_dt_err), 64'd0);
      chk("bad_no_rsp", 64'({apb_psel, a2l_valid}), 64'd0);

      // Timeout on a read with no pready
      slv_hang = 1'b1;
      exp_q.push_back({33'h1_0000_0000, 16'd5, 8'h31});
      drive_req(8'h30, 32'h0000_5000, 32'd0);
      #1;
      chk("to_accept", 64'(l2a_accept), 64'd1);
      @(posedge clk); #1;
      l2a_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 400; k++) begin
         @(posedge clk); #1;
         if (apb_penable) n++;
         else break;
      end
      chk("to_access_cycles", 64'(n), 64'd256);
      chk("to_psel_drop", 64'(apb_psel), 64'd0);
      chk("to_err_pulse", 64'(timeout_err), 64'd1);
      check_rsp("to_rsp");
      @(posedge clk); #1;
      chk("to_err_end", 64'(timeout_err), 64'd0);
      chk("to_valid_drop", 64'(a2l_valid), 64'd0);
      slv_hang = 1'b0;

      // Back-pressure with a second request waiting
      a2l_ready = 1'b0;
      slv_waits = 0; slv_rdata = 32'hCAFE_F00D; slv_err = 1'b0;
      exp_q.push_back({33'h0_0000_0000, 16'd1, 8'h33});
      exp_q.push_back({33'h0_CAFE_F00D, 16'd5, 8'h31});
      drive_req(8'h32, 32'h0000_6000, 32'h1111_2222);
      #1;
      chk("bp_acceptA", 64'(l2a_accept), 64'd1);
      @(posedge clk); #1;
      drive_req(8'h30, 32'h0000_7000, 32'd0);
      #1;
      flag = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (a2l_valid) break;
         if (l2a_accept) flag = 1'b1;
         @(posedge clk); #1;
      end
      snap = a2l_data;
      check_rsp("bp_rspA");
      flag2 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (!a2l_valid || a2l_data !== snap || l2a_accept) flag2 = 1'b1;
      end
      chk("bp_no_early_accept", 64'(flag), 64'd0);
      chk("bp_held_stable", 64'(flag2), 64'd0);
      a2l_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid_drop", 64'(a2l_valid), 64'd0);
      chk("bp_acceptB", 64'(l2a_accept), 64'd1);
      @(posedge clk); #1;
      l2a_valid = 1'b0;
      chk("bp_pselB", 64'(apb_psel), 64'd1);
      chk("bp_paddrB", 64'(apb_paddr), 64'h7000);
      n = 0;
      while (!a2l_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_rsp("bp_rspB");
      @(posedge clk); #1;

      // enable dropped during ACCESS: transfer completes, no response
      slv_waits = 4; slv_rdata = 32'h0101_0101; slv_err = 1'b0;
      drive_req(8'h30, 32'h0000_8000, 32'd0);
      #1;
      chk("en_accept", 64'(l2a_accept), 64'd1);
      @(posedge clk); #1;
      l2a_valid = 1'b0;
      @(posedge clk); #1;
      enable = 1'b0;
      n = apb_penable ? 1 : 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (apb_penable) n++;
         else break;
      end
      chk("en_access_cycles", 64'(n), 64'd5);
      chk("en_psel_drop", 64'(apb_psel), 64'd0);
      flag = a2l_valid;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (a2l_valid) flag = 1'b1;
      end
      chk("en_no_rsp", 64'(flag), 64'd0);
      enable = 1'b1;

      // enable dropped while a response waits: response discarded
      a2l_ready = 1'b0;
      slv_waits = 0; slv_rdata = 32'h0202_0202; slv_err = 1'b0;
      exp_q.push_back({33'h0_0202_0202, 16'd5, 8'h31});
      drive_req(8'h30, 32'h0000_8100, 32'd0);
      @(posedge clk); #1;
      l2a_valid = 1'b0;
      n = 0;
      while (!a2l_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_rsp("rspdis_rsp");
      enable = 1'b0;
      @(posedge clk); #1;
      chk("rspdis_valid_drop", 64'(a2l_valid), 64'd0);
      enable = 1'b1;
      a2l_ready = 1'b1;
      @(posedge clk); #1;
      chk("rspdis_stays_idle", 64'({a2l_valid, apb_psel}), 64'd0);

      // Asynchronous reset in the middle of ACCESS
      slv_hang = 1'b1;
      drive_req(8'h32, 32'h0000_9000, 32'h9999_9999);
      @(posedge clk); #1;
      l2a_valid = 1'b0;
      @(posedge clk); #1;
      chk("arst_in_access", 64'({apb_psel, apb_penable}), 64'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_psel", 64'({apb_psel, apb_penable}), 64'd0);
      chk("arst_paddr", 64'(apb_paddr), 64'd0);
      chk("arst_a2l", 64'({a2l_valid, a2l_data}), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      slv_hang = 1'b0;
      @(posedge clk); #1;

      // Recovery after reset
      run_vec(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
